// File: rtl/b_capture_pkg.sv
// Shared types and helpers for the moduleB capture block.
package b_capture_pkg;

    // Width and ceiling of the overflow drop counter.
    localparam int unsigned DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Capture FSM: IDLE waits for enable, FIRST takes one unconditional
    // sample, TRACK captures only when the input value changes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_TRACK = 2'd2
    } cap_state_e;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/b_capture_fifo.sv
// Small synchronous FIFO holding {tag, data} captures; head is read combinationally.
module b_capture_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     push_ok,
    output logic                     pop_ok,
    output logic [W-1:0]             head_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;

    assign valid     = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // Pop only with data present; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        pop_ok   = pop & valid;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are irrelevant once level is cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/b_capture.sv
// Captures changing moduleB output values with their sideband tag into a FIFO,
// counting captures lost to overflow.
`ifndef DATA_FROM_B_BITWIDTH
`define DATA_FROM_B_BITWIDTH 8
`endif
`ifndef B_EXTRA_OUT_BITWIDTH
`define B_EXTRA_OUT_BITWIDTH 4
`endif

module b_capture
    import b_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = `DATA_FROM_B_BITWIDTH,
    parameter int unsigned TW    = `B_EXTRA_OUT_BITWIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           data_from_B,
    input  logic [TW-1:0]           b_extra_out,
    input  logic                    cap_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [TW-1:0]           out_tag,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level,
    output logic [DROP_W-1:0]       drop_cnt
);

    cap_state_e          state_q, state_d;
    logic [DW-1:0]       last_val_q, last_val_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                push_req;
    logic                push_ok;
    logic                pop_ok;
    logic [TW+DW-1:0]    head;

    assign drop_cnt = drop_cnt_q;
    assign out_tag  = head[TW+DW-1:DW];
    assign out_data = head[DW-1:0];

    b_capture_fifo #(
        .DEPTH (DEPTH),
        .W     (TW + DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data ({b_extra_out, data_from_B}),
        .pop       (out_ready),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .head_data (head),
        .valid     (out_valid),
        .full      (full),
        .level     (level)
    );

    // Next-state, capture request and drop accounting.
    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        drop_cnt_d = drop_cnt_q;
        push_req   = 1'b0;
        if (!cap_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FIRST;
                end
                ST_FIRST: begin
                    push_req   = 1'b1;
                    last_val_d = data_from_B;
                    state_d    = ST_TRACK;
                end
                ST_TRACK: begin
                    if (data_from_B != last_val_q) begin
                        push_req   = 1'b1;
                        last_val_d = data_from_B;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (push_req && !push_ok) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // FSM, last-seen value and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_val_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
